// File: rtl/exp_seq_pkg.sv
// Shared types and constants for the exp job sequencer.
package exp_seq_pkg;

    localparam int XW_DEF    = 16;
    localparam int RW_DEF    = 18;
    localparam int TAG_W_DEF = 4;

    localparam logic [17:0] EXP_SAT = 18'h3FFFF;
    localparam logic [17:0] EXP_ONE = 18'h10000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/exp_seq_outbuf.sv
// One-entry valid/ready holding register for a captured exp result.
module exp_seq_outbuf
    import exp_seq_pkg::*;
#(
    parameter int RW    = RW_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic [RW-1:0]    i_data,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_sat,
    input  logic             i_timeout,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [RW-1:0]    o_data,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_sat,
    output logic             o_timeout,
    output logic             o_free
);

    logic             r_valid;
    logic [RW-1:0]    r_data;
    logic [TAG_W-1:0] r_tag;
    logic             r_sat;
    logic             r_timeout;

    // The slot can be refilled in the same cycle its current entry drains.
    assign o_free = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_tag     <= '0;
            r_sat     <= 1'b0;
            r_timeout <= 1'b0;
        end else if (i_capture) begin
            r_valid   <= 1'b1;
            r_data    <= i_data;
            r_tag     <= i_tag;
            r_sat     <= i_sat;
            r_timeout <= i_timeout;
        end else if (i_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_tag     = r_tag;
    assign o_sat     = r_sat;
    assign o_timeout = r_timeout;

endmodule

// File: rtl/exp_job_sequencer.sv
// Job front-end for the Maclaurin exp engine: operand stream -> start/done -> result stream.
// Optional ISSUE watchdog enabled by defining EXP_SEQ_TIMEOUT_EN.
module exp_job_sequencer
    import exp_seq_pkg::*;
#(
    parameter int XW      = XW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [XW-1:0]    inX,
    input  logic [TAG_W-1:0] inTag,
    output logic             engStart,
    output logic [XW-1:0]    engX,
    input  logic             engDone,
    input  logic [RW-1:0]    engResult,
    output logic             resValid,
    input  logic             resReady,
    output logic [RW-1:0]    resData,
    output logic [TAG_W-1:0] resTag,
    output logic             resSat,
    output logic             resTimeout,
    output logic             busy,
    output logic [15:0]      jobCnt
);

    seq_state_t       r_state;
    seq_state_t       w_stateNext;
    logic [XW-1:0]    r_engX;
    logic [TAG_W-1:0] r_tag;
    logic             r_engStart;
    logic [15:0]      r_jobCnt;

    logic             w_accept;
    logic             w_bufFree;
    logic             w_doneCapture;
    logic             w_toCapture;
    logic             w_capture;
    logic [RW-1:0]    w_capData;
    logic             w_capSat;

    assign inReady       = (r_state == IDLE) && !rst;
    assign w_accept      = inValid && inReady;
    assign w_doneCapture = (r_state == ISSUE) && engDone && w_bufFree;

`ifdef EXP_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_toCnt;

    // Only cycles genuinely waiting on the engine count; a stall on a full buffer does not.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_toCnt <= '0;
        end else if ((r_state == ISSUE) && !engDone && (r_toCnt != TO_W'(TIMEOUT))) begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end

    assign w_toCapture = (r_state == ISSUE) && !engDone &&
                         (r_toCnt == TO_W'(TIMEOUT)) && w_bufFree;
`else
    logic w_unusedTimeout;
    assign w_unusedTimeout = (TIMEOUT != 0);
    assign w_toCapture     = 1'b0;
`endif

    assign w_capture = w_doneCapture || w_toCapture;
    assign w_capData = w_toCapture ? '0 : engResult;
    assign w_capSat  = !w_toCapture && (engResult == RW'(EXP_SAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)  w_stateNext = ISSUE;
            ISSUE:   if (w_capture) w_stateNext = RELEASE;
            // Wait for the engine to leave DONE before another start can be issued.
            RELEASE: if (!engDone)  w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_engStart <= 1'b0;
            r_engX     <= '0;
            r_tag      <= '0;
            r_jobCnt   <= '0;
        end else begin
            r_engStart <= (w_stateNext == ISSUE);
            if (w_accept) begin
                r_engX <= inX;
                r_tag  <= inTag;
            end
            if (w_capture) begin
                r_jobCnt <= r_jobCnt + 16'd1;
            end
        end
    end

    exp_seq_outbuf #(
        .RW    (RW),
        .TAG_W (TAG_W)
    ) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_capture),
        .i_data    (w_capData),
        .i_tag     (r_tag),
        .i_sat     (w_capSat),
        .i_timeout (w_toCapture),
        .i_ready   (resReady),
        .o_valid   (resValid),
        .o_data    (resData),
        .o_tag     (resTag),
        .o_sat     (resSat),
        .o_timeout (resTimeout),
        .o_free    (w_bufFree)
    );

    assign engStart = r_engStart;
    assign engX     = r_engX;
    assign busy     = (r_state != IDLE);
    assign jobCnt   = r_jobCnt;

endmodule

// File: tb/tb_exp_job_sequencer.sv
// Scoreboard bench for exp_job_sequencer with a behavioural 8-term engine stand-in.
`timescale 1ns/1ps
module tb_exp_job_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [15:0] inX;
    logic [3:0]  inTag;
    logic        engStart;
    logic [15:0] engX;
    logic        engDone;
    logic [17:0] engResult;
    logic        resValid;
    logic        resReady;
    logic [17:0] resData;
    logic [3:0]  resTag;
    logic        resSat;
    logic        resTimeout;
    logic        busy;
    logic [15:0] jobCnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_total = 0;
    int hold_extra = 0;

    typedef struct packed {
        logic [17:0] data;
        logic [3:0]  tag;
        logic        sat;
    } exp_t;
    exp_t sb[$];

    exp_job_sequencer dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady), .inX(inX), .inTag(inTag),
        .engStart(engStart), .engX(engX), .engDone(engDone), .engResult(engResult),
        .resValid(resValid), .resReady(resReady), .resData(resData), .resTag(resTag),
        .resSat(resSat), .resTimeout(resTimeout), .busy(busy), .jobCnt(jobCnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in engine result: exact exp values for the reference points, saturation for x ending in F.
    function automatic logic [17:0] eng_fn(input logic [15:0] x);
        if (x == 16'h0000)      return 18'h10000;
        else if (x == 16'h8000) return 18'h1A612;
        else if (x == 16'hFFFF) return 18'h2B7E1;
        else if (x[3:0] == 4'hF) return 18'h3FFFF;
        else return {2'b01, x} ^ 18'h00A5A;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic void bound_fail(string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endfunction

    // Engine: done 26 sampled start cycles after start rises; drops done hold_extra cycles after start falls.
    int e_cnt;
    int e_hold;
    always @(posedge clk) begin
        if (rst) begin
            engDone <= 1'b0;
            e_cnt   <= 0;
            e_hold  <= 0;
        end else if (!engDone) begin
            if (engStart) begin
                if (e_cnt == 25) begin
                    engDone <= 1'b1;
                    e_cnt   <= 0;
                end else begin
                    e_cnt <= e_cnt + 1;
                end
            end else begin
                e_cnt <= 0;
            end
        end else if (!engStart) begin
            if (e_hold >= hold_extra) begin
                engDone <= 1'b0;
                e_hold  <= 0;
            end else begin
                e_hold <= e_hold + 1;
            end
        end
    end
    assign engResult = engDone ? eng_fn(engX) : 18'h0;

    // Issue side: every accepted operand pushes its expected result.
    always @(negedge clk) begin
        if (!rst && inValid && inReady) begin
            exp_t e;
            e.data = eng_fn(inX);
            e.tag  = inTag;
            e.sat  = (eng_fn(inX) == 18'h3FFFF);
            sb.push_back(e);
            acc_total <= acc_total + 1;
        end
    end

    // Monitor: pops on every result handshake, checks hold-stability and start/done ordering.
    logic        p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1, p_start = 1'b0;
    logic [17:0] p_data  = '0;
    logic [3:0]  p_tag   = '0;
    logic        p_sat   = 1'b0, p_to = 1'b0;
    always @(negedge clk) begin
        if (!rst && !p_rst && p_valid && !p_ready && resValid) begin
            chk("hold_data", {14'h0, resData}, {14'h0, p_data});
            chk("hold_tag", {28'h0, resTag}, {28'h0, p_tag});
            chk("hold_sat", {31'h0, resSat}, {31'h0, p_sat});
            chk("hold_timeout", {31'h0, resTimeout}, {31'h0, p_to});
        end
        if (!rst && engStart && !p_start)
            chk("start_while_done", {31'h0, engDone}, 32'h0);
        if (!rst && resValid && resReady) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=tag%0h expected=no_result", resTag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", {14'h0, resData}, {14'h0, e.data});
                chk("res_tag", {28'h0, resTag}, {28'h0, e.tag});
                chk("res_sat", {31'h0, resSat}, {31'h0, e.sat});
                chk("res_timeout", {31'h0, resTimeout}, 32'h0);
            end
        end
        p_valid <= resValid;
        p_ready <= resReady;
        p_rst   <= rst;
        p_start <= engStart;
        p_data  <= resData;
        p_tag   <= resTag;
        p_sat   <= resSat;
        p_to    <= resTimeout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [3:0] tag, input bit keep,
                        output int acc_cyc);
        int n;
        inValid = 1'b1;
        inX     = x;
        inTag   = tag;
        n       = 0;
        acc_cyc = -1;
        while (!inReady && n < 400) begin
            tick();
            n++;
        end
        if (inReady) begin
            acc_cyc = cyc;
            tick();
        end else begin
            bound_fail("send_accept");
        end
        if (!keep) inValid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || resValid) && n < 500) begin
            tick();
            n++;
        end
        if (busy || resValid) bound_fail(name);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, n, sent, acc_base;
        bit got;
        rst = 1'b1; inValid = 1'b0; inX = '0; inTag = '0; resReady = 1'b0;
        repeat (3) tick();
        chk("rst_inReady", {31'h0, inReady}, 32'h0);
        rst = 1'b0;
        acc_base = acc_total;
        tick();
        chk("rst_engStart", {31'h0, engStart}, 32'h0);
        chk("rst_resValid", {31'h0, resValid}, 32'h0);
        chk("rst_resSat", {31'h0, resSat}, 32'h0);
        chk("rst_resTimeout", {31'h0, resTimeout}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_engX", {16'h0, engX}, 32'h0);
        chk("rst_resData", {14'h0, resData}, 32'h0);
        chk("rst_resTag", {28'h0, resTag}, 32'h0);
        chk("rst_jobCnt", {16'h0, jobCnt}, 32'h0);
        chk("idle_inReady", {31'h0, inReady}, 32'h1);

        // Single job latency
        resReady = 1'b1;
        send(16'h0000, 4'd3, 1'b0, a0);
        n = 0;
        while (!resValid && n < 100) begin tick(); n++; end
        if (!resValid) bound_fail("lat_res");
        else chk("lat_res", cyc - a0, 28);
        n = 0;
        while (!inReady && n < 100) begin tick(); n++; end
        if (!inReady) bound_fail("lat_ready");
        else chk("lat_ready", cyc - a0, 30);
        chk("jobcnt_1", {16'h0, jobCnt}, 32'd1);

        // Back-to-back with inValid held
        send(16'h8000, 4'd5, 1'b1, a1);
        send(16'hFFFF, 4'd6, 1'b0, a2);
        chk("b2b_gap", a2 - a1, 30);
        wait_idle("b2b_drain");
        chk("jobcnt_3", {16'h0, jobCnt}, 32'd3);

        // Backpressure: second job stalls in ISSUE with done high
        resReady = 1'b0;
        send(16'h1234, 4'd7, 1'b0, a0);
        n = 0;
        while (!resValid && n < 100) begin tick(); n++; end
        if (!resValid) bound_fail("bp_first");
        send(16'h4321, 4'd8, 1'b0, a1);
        n = 0;
        while (!engDone && n < 100) begin tick(); n++; end
        if (!engDone) bound_fail("bp_done");
        repeat (8) begin
            tick();
            chk("bp_start_held", {31'h0, engStart}, 32'h1);
            chk("bp_first_tag", {28'h0, resTag}, 32'd7);
        end
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        chk("bp_second_valid", {31'h0, resValid}, 32'h1);
        chk("bp_second_tag", {28'h0, resTag}, 32'd8);
        resReady = 1'b1;
        wait_idle("bp_drain");
        chk("jobcnt_5", {16'h0, jobCnt}, 32'd5);

        // Reset mid-job
        send(16'h0ABC, 4'd9, 1'b0, a0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        chk("midrst_engStart", {31'h0, engStart}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_resValid", {31'h0, resValid}, 32'h0);
        chk("midrst_jobCnt", {16'h0, jobCnt}, 32'h0);
        rst = 1'b0;
        sb.delete();
        acc_base = acc_total;
        tick();
        send(16'h0001, 4'd10, 1'b0, a0);
        wait_idle("midrst_drain");
        chk("midrst_jobcnt", {16'h0, jobCnt}, acc_total - acc_base);

        // Engine holding done longer delays return to IDLE
        hold_extra = 5;
        send(16'h0002, 4'd11, 1'b0, a0);
        n = 0;
        while (!inReady && n < 100) begin tick(); n++; end
        if (!inReady) bound_fail("hold_idle");
        else chk("hold_idle", cyc - a0, 35);
        hold_extra = 0;
        wait_idle("hold_drain");

        // Randomized traffic with random backpressure
        sent = 0;
        inValid = 1'b0;
        for (int c = 0; c < 8000 && sent < 40; c++) begin
            if (!inValid && ($urandom_range(0, 3) != 0)) begin
                inValid = 1'b1;
                inX     = 16'($urandom);
                inTag   = 4'($urandom);
            end
            resReady = ($urandom_range(0, 2) != 0);
            got = inValid && inReady;
            tick();
            if (got) begin
                sent++;
                inValid = 1'b0;
            end
        end
        inValid  = 1'b0;
        resReady = 1'b1;
        wait_idle("rand_drain");
        tick();
        chk("rand_sent", sent, 40);
        chk("sb_empty", sb.size(), 0);
        chk("jobcnt_final", {16'h0, jobCnt}, (acc_total - acc_base) & 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
